intersection_phase_scheduler: RTL

Four-approach intersection scheduler that shares one green phase among four directions using vehicle-sensor requests. Direction selection is round-robin. Each green phase runs through a minimum green time, then gap-out or max-out, then yellow, then an all-red clearance interval. An emergency-preemption input overrides normal sequencing. The block sits above the per-signal light drivers: they consume its one-hot grant and phase code.

---
 rtl/intersection_phase_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/intersection_phase_scheduler.sv
// Round-robin four-approach green-phase scheduler with emergency preemption.
// Phase sequence: GREEN -> YELLOW -> ALL_RED, then either a new GREEN or IDLE.
module intersection_phase_scheduler #(
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 30,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2,
  parameter int CNT_W        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
  output logic [3:0] grant,
  output logic [1:0] light_state,
  output logic [1:0] active_dir,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2,
    S_ALL_RED = 2'd3
  } state_t;

  localparam logic [1:0] LS_RED    = 2'b00;
  localparam logic [1:0] LS_GREEN  = 2'b01;
  localparam logic [1:0] LS_YELLOW = 2'b10;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TIME - 1);

  state_t           state_q;
  logic [CNT_W-1:0] timer_q;
  logic [1:0]       last_q;

  logic [1:0] sel_dir;
  logic [1:0] cand;
  logic       sel_valid;
  logic [3:0] sel_oh;
  logic [3:0] act_oh;
  logic       other;
  logic       green_exit;

  // Preempt wins outright; otherwise scan from the direction after last, wrapping.
  always_comb begin
    sel_dir = preempt_dir;
    cand    = '0;
    if (!preempt) begin
      sel_dir = last_q;
      for (int k = 4; k >= 1; k--) begin
        cand = last_q + 2'(k);
        if (req[cand]) begin
          sel_dir = cand;
        end
      end
    end
  end

  assign sel_valid = preempt | (|req);
  assign sel_oh    = 4'b0001 << sel_dir;
  assign act_oh    = 4'b0001 << active_dir;
  assign other     = |(req & ~act_oh);

  always_comb begin
    green_exit = 1'b0;
    if (preempt) begin
      green_exit = (preempt_dir != active_dir);
    end else if (other) begin
      green_exit = (timer_q >= MAX_LAST) ||
                   ((timer_q >= MIN_LAST) && !req[active_dir]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      last_q      <= 2'd3;
      grant       <= 4'b0000;
      light_state <= LS_RED;
      active_dir  <= 2'd0;
      busy        <= 1'b0;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (sel_valid) begin
            state_q     <= S_GREEN;
            timer_q     <= '0;
            last_q      <= sel_dir;
            active_dir  <= sel_dir;
            grant       <= sel_oh;
            light_state <= LS_GREEN;
            busy        <= 1'b1;
          end
        end

        S_GREEN: begin
          if (green_exit) begin
            state_q     <= S_YELLOW;
            timer_q     <= '0;
            grant       <= 4'b0000;
            light_state <= LS_YELLOW;
          end else if (timer_q < MAX_LAST) begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_YELLOW: begin
          if (timer_q == YEL_LAST) begin
            state_q     <= S_ALL_RED;
            timer_q     <= '0;
            light_state <= LS_RED;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_ALL_RED: begin
          if (timer_q == AR_LAST) begin
            timer_q <= '0;
            if (sel_valid) begin
              state_q     <= S_GREEN;
              last_q      <= sel_dir;
              active_dir  <= sel_dir;
              grant       <= sel_oh;
              light_state <= LS_GREEN;
            end else begin
              state_q <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule
